// File: rtl/mem_stage_pipe.sv
// MEM stage of the 16-bit ASIP pipeline: data-memory load/store through a req/ack
// handshake with an access timeout, producing the registered MEM/WB bundle.
module mem_stage_pipe #(
  parameter int ARQ              = 16,
  parameter int MEMORY_ADDR_SIZE = 13,
  parameter int TIMEOUT          = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_enable_mem_in,
  input  logic                        rd_mem_mem_in,
  input  logic                        wr_mem_mem_in,
  input  logic                        mux_exe_out,
  input  logic                        pc_mem_in,
  input  logic [ARQ-1:0]              src1_mem_in,
  input  logic [ARQ-1:0]              src3_mem_in,
  input  logic [ARQ-1:0]              alu_result_mem_in,
  output logic                        mem_stall,
  output logic                        dmem_req,
  output logic                        dmem_we,
  output logic [MEMORY_ADDR_SIZE-1:0] dmem_addr,
  output logic [ARQ-1:0]              dmem_wdata,
  input  logic [ARQ-1:0]              dmem_rdata,
  input  logic                        dmem_ack,
  output logic                        wb_valid,
  output logic [ARQ-1:0]              wb_result,
  output logic                        wb_enable_out,
  output logic                        pc_wb_out,
  output logic [ARQ-1:0]              wb_src1_out,
  output logic                        mem_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             alu_op, issue, ack_hit, tmo_hit;

  logic             we_p1, load_sel_p1, wb_en_p1, pc_p1;
  logic [ARQ-1:0]   src1_p1, src3_p1, alu_p1;

  always_comb begin
    state_nxt = state;
    alu_op    = 1'b0;
    issue     = 1'b0;
    ack_hit   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (rd_mem_mem_in || wr_mem_mem_in) begin
          issue     = 1'b1;
          state_nxt = ACCESS;
        end else begin
          alu_op = 1'b1;
        end
      end
      ACCESS: begin
        // An ack arriving on the last allowed cycle still completes the access.
        if (dmem_ack) begin
          ack_hit   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        cnt <= '0;
      end else if (state == ACCESS && !dmem_ack) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (tmo_hit) begin
        mem_err <= 1'b1;
      end
    end
  end

  // ---- stage p1: bundle latched for the duration of a memory access ----
  always_ff @(posedge clk) begin
    if (issue) begin
      we_p1       <= wr_mem_mem_in;
      load_sel_p1 <= rd_mem_mem_in && !wr_mem_mem_in && mux_exe_out;
      wb_en_p1    <= wb_enable_mem_in;
      pc_p1       <= pc_mem_in;
      src1_p1     <= src1_mem_in;
      src3_p1     <= src3_mem_in;
      alu_p1      <= alu_result_mem_in;
    end
  end

  assign mem_stall  = (state != IDLE);
  assign dmem_req   = (state == ACCESS);
  assign dmem_we    = dmem_req && we_p1;
  assign dmem_addr  = dmem_req ? alu_p1[MEMORY_ADDR_SIZE-1:0] : '0;
  assign dmem_wdata = dmem_req ? src3_p1 : '0;

  // ---- stage p2: registered MEM/WB bundle ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_result     <= '0;
      wb_enable_out <= 1'b0;
      pc_wb_out     <= 1'b0;
      wb_src1_out   <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (alu_op) begin
        wb_valid      <= 1'b1;
        wb_result     <= alu_result_mem_in;
        wb_enable_out <= wb_enable_mem_in;
        pc_wb_out     <= pc_mem_in;
        wb_src1_out   <= src1_mem_in;
      end else if (ack_hit) begin
        wb_valid      <= 1'b1;
        wb_result     <= load_sel_p1 ? dmem_rdata : alu_p1;
        wb_enable_out <= wb_en_p1;
        pc_wb_out     <= pc_p1;
        wb_src1_out   <= src1_p1;
      end else if (tmo_hit) begin
        // Squashed instruction: the bundle is emitted but writes nothing.
        wb_valid      <= 1'b1;
        wb_result     <= alu_p1;
        wb_enable_out <= 1'b0;
        pc_wb_out     <= 1'b0;
        wb_src1_out   <= src1_p1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Testbench for mem_stage_pipe: table-driven ALU vectors, directed memory sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_mem_stage_pipe;
  localparam int ARQ = 16;
  localparam int AW  = 13;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, wb_en, rd, wr, mux, pc, ack;
  logic [ARQ-1:0]  src1, src3, alu, rdata;
  logic            mem_stall, dmem_req, dmem_we, wb_valid, wb_enable_out, pc_wb_out, mem_err;
  logic [AW-1:0]   dmem_addr;
  logic [ARQ-1:0]  dmem_wdata, wb_result, wb_src1_out;

  mem_stage_pipe #(.ARQ(ARQ), .MEMORY_ADDR_SIZE(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .wb_enable_mem_in(wb_en), .rd_mem_mem_in(rd), .wr_mem_mem_in(wr),
    .mux_exe_out(mux), .pc_mem_in(pc),
    .src1_mem_in(src1), .src3_mem_in(src3), .alu_result_mem_in(alu),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(rdata), .dmem_ack(ack),
    .wb_valid(wb_valid), .wb_result(wb_result), .wb_enable_out(wb_enable_out),
    .pc_wb_out(pc_wb_out), .wb_src1_out(wb_src1_out), .mem_err(mem_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one pending memory operation plus a count of cycles waited on it.
  bit             m_busy = 0;
  int             m_wait = 0;
  bit             m_we, m_ld_mux, m_en, m_pc;
  logic [ARQ-1:0] m_src1, m_src3, m_alu;
  bit             e_valid = 0, e_en = 0, e_pc = 0, e_err = 0, e_known = 1;
  logic [ARQ-1:0] e_res = '0, e_src1 = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; e_valid = 0; e_en = 0; e_pc = 0; e_err = 0;
      e_res = '0; e_src1 = '0; e_known = 1;
    end else if (!m_busy) begin
      if (rd || wr) begin
        m_busy = 1; m_wait = 0; m_we = wr; m_ld_mux = rd && !wr && mux;
        m_en = wb_en; m_pc = pc; m_src1 = src1; m_src3 = src3; m_alu = alu;
        e_valid = 0;
      end else begin
        e_valid = 1; e_res = alu; e_en = wb_en; e_pc = pc; e_src1 = src1; e_known = 1;
      end
    end else if (ack) begin
      e_valid = 1; e_res = m_ld_mux ? rdata : m_alu;
      e_en = m_en; e_pc = m_pc; e_src1 = m_src1; e_known = 1; m_busy = 0;
    end else if (m_wait == TMO - 1) begin
      e_valid = 1; e_en = 0; e_pc = 0; e_err = 1; e_known = 0; m_busy = 0;
    end else begin
      m_wait++; e_valid = 0;
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_wb_valid", wb_valid, e_valid);
      chk("m_wb_en", wb_enable_out, e_en);
      chk("m_pc_wb", pc_wb_out, e_pc);
      chk("m_mem_err", mem_err, e_err);
      chk("m_stall", mem_stall, m_busy);
      chk("m_req", dmem_req, m_busy);
      if (m_busy) begin
        chk("m_we", dmem_we, m_we);
        chk("m_addr", dmem_addr, m_alu[AW-1:0]);
        chk("m_wdata", dmem_wdata, m_src3);
      end
      if (e_known) begin
        chk("m_result", wb_result, e_res);
        chk("m_src1", wb_src1_out, e_src1);
      end
    end
  end

  task automatic idle_in();
    rd = 0; wr = 0; ack = 0; wb_en = 0; pc = 0; mux = 0;
    alu = '0; src1 = '0; src3 = '0; rdata = '0;
  endtask

  typedef struct {
    logic [ARQ-1:0] alu;
    logic [ARQ-1:0] src1;
    bit             en;
    bit             pc;
    bit             mux;
    logic [ARQ-1:0] exp_res;
    bit             exp_en;
    bit             exp_pc;
  } vec_t;

  vec_t tbl[4];
  int   cnt;

  initial begin
    tbl[0] = '{16'h0042, 16'h1111, 1'b1, 1'b0, 1'b0, 16'h0042, 1'b1, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1};
    tbl[2] = '{16'h8000, 16'hABCD, 1'b1, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1};
    tbl[3] = '{16'h0000, 16'h5A5A, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};

    rst = 1; idle_in();
    repeat (2) @(negedge clk);
    chk("rst_valid", wb_valid, 0);
    chk("rst_result", wb_result, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_en", wb_enable_out, 0);
    rst = 0;
    chk_en = 1;

    // Back-to-back ALU ops, one per cycle
    for (int i = 0; i < 4; i++) begin
      alu = tbl[i].alu; src1 = tbl[i].src1; wb_en = tbl[i].en; pc = tbl[i].pc; mux = tbl[i].mux;
      @(negedge clk);
      chk("alu_valid", wb_valid, 1);
      chk("alu_result", wb_result, tbl[i].exp_res);
      chk("alu_en", wb_enable_out, tbl[i].exp_en);
      chk("alu_pc", pc_wb_out, tbl[i].exp_pc);
      chk("alu_src1", wb_src1_out, tbl[i].src1);
      chk("alu_stall", mem_stall, 0);
    end

    // Load, ack on the 4th access cycle; address must hold while inputs change
    idle_in(); rd = 1; mux = 1; alu = 16'h2005; wb_en = 1; src1 = 16'h0F0F;
    cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (mem_stall) cnt++;
      chk("ld_req", dmem_req, 1);
      chk("ld_addr", dmem_addr, 13'h0005);
      chk("ld_we", dmem_we, 0);
      idle_in(); alu = 16'($urandom); src3 = 16'($urandom);
      ack = (k == 4); rdata = 16'hBEEF;
    end
    @(negedge clk);
    idle_in();
    chk("ld_stall_cycles", cnt, 4);
    chk("ld_stall_end", mem_stall, 0);
    chk("ld_valid", wb_valid, 1);
    chk("ld_result", wb_result, 16'hBEEF);
    chk("ld_src1", wb_src1_out, 16'h0F0F);

    // Store with immediate ack
    wr = 1; alu = 16'h0010; src3 = 16'h1234; wb_en = 1;
    @(negedge clk);
    chk("st_we", dmem_we, 1);
    chk("st_addr", dmem_addr, 13'h0010);
    chk("st_wdata", dmem_wdata, 16'h1234);
    idle_in(); src3 = 16'h9999; ack = 1;
    @(negedge clk);
    idle_in();
    chk("st_valid", wb_valid, 1);
    chk("st_en", wb_enable_out, 1);
    chk("st_stall", mem_stall, 0);

    // rd=wr=1 acts as a store; ack arrives on the final allowed cycle
    rd = 1; wr = 1; mux = 1; alu = 16'h0ABC; src3 = 16'h7777; wb_en = 1; pc = 1;
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      chk("rw_req", dmem_req, 1);
      if (k == 1) begin
        chk("rw_we", dmem_we, 1);
        chk("rw_wdata", dmem_wdata, 16'h7777);
      end
      idle_in();
      ack = (k == TMO); rdata = 16'hDEAD;
    end
    @(negedge clk);
    idle_in();
    chk("rw_err", mem_err, 0);
    chk("rw_valid", wb_valid, 1);
    chk("rw_result", wb_result, 16'h0ABC);
    chk("rw_en", wb_enable_out, 1);
    chk("rw_pc", pc_wb_out, 1);

    // Timeout: no ack at all
    rd = 1; alu = 16'h0033; wb_en = 1; pc = 1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      idle_in();
      if (dmem_req) cnt++;
      else break;
    end
    chk("tmo_req_cycles", cnt, TMO);
    chk("tmo_valid", wb_valid, 1);
    chk("tmo_en", wb_enable_out, 0);
    chk("tmo_pc", pc_wb_out, 0);
    chk("tmo_err", mem_err, 1);
    repeat (3) @(negedge clk);
    chk("tmo_err_sticky", mem_err, 1);

    // Reset in the middle of an access
    rd = 1; alu = 16'h0100; wb_en = 1;
    @(negedge clk);
    chk("rsta_req", dmem_req, 1);
    idle_in(); rst = 1;
    @(negedge clk);
    chk("rsta_req0", dmem_req, 0);
    chk("rsta_stall", mem_stall, 0);
    chk("rsta_valid", wb_valid, 0);
    chk("rsta_result", wb_result, 0);
    chk("rsta_en", wb_enable_out, 0);
    chk("rsta_err", mem_err, 0);
    rst = 0; alu = 16'h0077; wb_en = 1;
    @(negedge clk);
    idle_in();
    chk("rsta_alu_valid", wb_valid, 1);
    chk("rsta_alu_result", wb_result, 16'h0077);
    chk("rsta_alu_en", wb_enable_out, 1);

    // Randomized traffic against the reference model
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      rst   = ($urandom_range(99) == 0);
      rd    = ($urandom_range(3) == 0);
      wr    = ($urandom_range(4) == 0);
      ack   = ($urandom_range(4) == 0);
      mux   = 1'($urandom);
      wb_en = 1'($urandom);
      pc    = 1'($urandom);
      alu   = 16'($urandom);
      src1  = 16'($urandom);
      src3  = 16'($urandom);
      rdata = 16'($urandom);
    end
    @(negedge clk);
    rst = 0; idle_in();
    repeat (TMO + 2) @(negedge clk);
    chk_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
